// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between IF (fetch) and MEM (load/store): grant in IDLE, 1 cycle to issue, response passed through.
// One transaction outstanding; bus_req_valid holds until bus_req_ready; MEM has priority with a bounded streak so IF cannot starve.
module mem_port_arbiter #(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int MAX_MEM_STREAK = 4,
   parameter int TIMEOUT        = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_req_addr,
   input  logic              if_flush,
   output logic              if_rsp_valid,
   output logic [DATA_W-1:0] if_rsp_data,
   input  logic              mem_req_valid,
   output logic              mem_req_ready,
   input  logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_wen,
   input  logic [DATA_W-1:0] mem_req_wdata,
   input  logic [7:0]        mem_req_wmask,
   output logic              mem_rsp_valid,
   output logic [DATA_W-1:0] mem_rsp_data,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic [ADDR_W-1:0] bus_req_addr,
   output logic              bus_req_wen,
   output logic [DATA_W-1:0] bus_req_wdata,
   output logic [7:0]        bus_req_wmask,
   input  logic              bus_rsp_valid,
   input  logic [DATA_W-1:0] bus_rsp_data,
   output logic              bus_timeout,
   output logic              busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   localparam int STRK_W = $clog2(MAX_MEM_STREAK + 1);
   localparam int TMO_W  = $clog2(TIMEOUT + 1);
   localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_MEM_STREAK);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic              owner_mem_q, owner_mem_d;
   logic              drop_q, drop_d;
   logic [STRK_W-1:0] streak_q, streak_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [7:0]        wmask_q, wmask_d;

   logic if_elig;
   logic grant_mem;
   logic grant_if;
   logic rsp_hit;
   logic tmo_hit;
   logic finish;

   always_comb begin
      if_elig   = if_req_valid & ~if_flush;
      grant_mem = (state_q == S_IDLE) & mem_req_valid & ~(if_elig & (streak_q == STRK_MAX));
      grant_if  = (state_q == S_IDLE) & if_elig & ~grant_mem;
      rsp_hit   = (state_q == S_WAIT) & bus_rsp_valid;
      // The timeout fires in the TIMEOUT-th WAIT cycle, counted from zero on entry.
      tmo_hit   = (state_q == S_WAIT) & ~bus_rsp_valid & (tmo_cnt_q == TMO_LAST);
      finish    = rsp_hit | tmo_hit;
   end

   always_comb begin
      state_d     = state_q;
      owner_mem_d = owner_mem_q;
      drop_d      = drop_q;
      streak_d    = streak_q;
      tmo_cnt_d   = tmo_cnt_q;
      addr_d      = addr_q;
      wen_d       = wen_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      case (state_q)
         S_IDLE: begin
            if (grant_mem || grant_if) begin
               state_d     = S_ISSUE;
               owner_mem_d = grant_mem;
               drop_d      = 1'b0;
               tmo_cnt_d   = '0;
               addr_d      = grant_mem ? mem_req_addr : if_req_addr;
               wen_d       = grant_mem & mem_req_wen;
               wdata_d     = grant_mem ? mem_req_wdata : '0;
               wmask_d     = grant_mem ? mem_req_wmask : 8'h00;
            end
            if (grant_if) begin
               streak_d = '0;
            end else if (grant_mem) begin
               if (!if_elig)
                  streak_d = '0;
               else if (streak_q != STRK_MAX)
                  streak_d = streak_q + STRK_W'(1);
            end
         end
         S_ISSUE: begin
            if (!owner_mem_q && if_flush)
               drop_d = 1'b1;
            if (bus_req_ready) begin
               state_d   = S_WAIT;
               tmo_cnt_d = '0;
            end
         end
         S_WAIT: begin
            if (!owner_mem_q && if_flush)
               drop_d = 1'b1;
            if (finish) begin
               state_d   = S_IDLE;
               drop_d    = 1'b0;
               tmo_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         owner_mem_q <= 1'b0;
         drop_q      <= 1'b0;
         streak_q    <= '0;
         tmo_cnt_q   <= '0;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         owner_mem_q <= owner_mem_d;
         drop_q      <= drop_d;
         streak_q    <= streak_d;
         tmo_cnt_q   <= tmo_cnt_d;
         addr_q      <= addr_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
      end
   end

   // Readies are combinational from inputs, so they are masked while reset is held.
   assign if_req_ready  = rst_n & grant_if;
   assign mem_req_ready = rst_n & grant_mem;

   // A flush arriving with the response still suppresses the IF pulse.
   assign if_rsp_valid  = finish & ~owner_mem_q & ~(drop_q | if_flush);
   assign mem_rsp_valid = finish & owner_mem_q;
   assign if_rsp_data   = (rsp_hit & if_rsp_valid) ? bus_rsp_data : '0;
   assign mem_rsp_data  = (rsp_hit & mem_rsp_valid) ? bus_rsp_data : '0;

   assign bus_req_valid = (state_q == S_ISSUE);
   assign bus_req_addr  = addr_q;
   assign bus_req_wen   = wen_q;
   assign bus_req_wdata = wdata_q;
   assign bus_req_wmask = wmask_q;
   assign bus_timeout   = tmo_hit;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: arbitration table, directed multi-cycle sequences, randomized run against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int AW   = 64;
   localparam int DW   = 64;
   localparam int MAXS = 4;
   localparam int TMO  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          if_req_valid, if_req_ready, if_flush, if_rsp_valid;
   logic [AW-1:0] if_req_addr;
   logic [DW-1:0] if_rsp_data;
   logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_req_wdata, mem_rsp_data;
   logic [7:0]    mem_req_wmask;
   logic          bus_req_valid, bus_req_ready, bus_req_wen, bus_rsp_valid, bus_timeout, busy;
   logic [AW-1:0] bus_req_addr;
   logic [DW-1:0] bus_req_wdata, bus_rsp_data;
   logic [7:0]    bus_req_wmask;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_MEM_STREAK(MAXS), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
      .bus_req_wen(bus_req_wen), .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
      .bus_timeout(bus_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [271:0] outs;
   assign outs = {if_req_ready, mem_req_ready, bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata,
                  bus_req_wmask, if_rsp_valid, if_rsp_data, mem_rsp_valid, mem_rsp_data, bus_timeout, busy};

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic if_v;
      logic flush;
      logic mem_v;
      logic exp_if;
      logic exp_mem;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      if_req_valid = 0; if_req_addr = '0; if_flush = 0;
      mem_req_valid = 0; mem_req_addr = '0; mem_req_wen = 0; mem_req_wdata = '0; mem_req_wmask = '0;
      bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_data = '0;
   endtask

   // Called right after the grant edge: completes the transaction with a 1-cycle issue and immediate response.
   task automatic finish_txn();
      if_req_valid = 0; mem_req_valid = 0; bus_req_ready = 1;
      tick();
      bus_req_ready = 0; bus_rsp_valid = 1;
      tick();
      bus_rsp_valid = 0;
   endtask

   // who: 1 = MEM granted, 0 = IF granted, -1 = none, 2 = both
   task automatic do_txn(input logic if_v, input logic mem_v, output int who);
      if_req_valid = if_v; mem_req_valid = mem_v; mem_req_wen = 0;
      settle();
      who = (mem_req_ready && if_req_ready) ? 2 : mem_req_ready ? 1 : if_req_ready ? 0 : -1;
      tick();
      finish_txn();
   endtask

   // Transaction-level reference model
   logic          m_act, m_mem, m_sent, m_drop, m_wen;
   int            m_wait, m_streak;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [7:0]    m_mask;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int who;
      logic exp_mem;
      clear_inputs();
      tbl[0] = '{0, 0, 0, 0, 0};
      tbl[1] = '{0, 0, 1, 0, 1};
      tbl[2] = '{1, 0, 0, 1, 0};
      tbl[3] = '{1, 0, 1, 0, 1};
      tbl[4] = '{0, 1, 0, 0, 0};
      tbl[5] = '{0, 1, 1, 0, 1};
      tbl[6] = '{1, 1, 0, 0, 0};
      tbl[7] = '{1, 1, 1, 0, 1};

      // Reset state
      rst_n = 0;
      tick(); tick();
      chk("reset_outs", outs, '0);
      rst_n = 1;
      settle();
      chk("post_reset_outs", outs, '0);

      // Arbitration table applied combinationally in IDLE (cleared before any edge samples it)
      for (int i = 0; i < 8; i++) begin
         if_req_valid = tbl[i].if_v; if_flush = tbl[i].flush; mem_req_valid = tbl[i].mem_v;
         settle();
         chk($sformatf("arb_tbl%0d", i), {if_req_ready, mem_req_ready}, {tbl[i].exp_if, tbl[i].exp_mem});
      end
      clear_inputs();

      // Single IF read
      tick();
      if_req_valid = 1; if_req_addr = 64'h8000_0000; bus_req_ready = 1;
      settle();
      chk("t1_grant", {if_req_ready, mem_req_ready}, 2'b10);
      tick();
      if_req_valid = 0;
      settle();
      chk("t1_issue", {bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wmask}, {1'b1, 64'h8000_0000, 1'b0, 8'h00});
      tick();
      bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_data = 64'h1234;
      settle();
      chk("t1_rsp", {if_rsp_valid, if_rsp_data, mem_rsp_valid}, {1'b1, 64'h1234, 1'b0});
      tick();
      bus_rsp_valid = 0;
      settle();
      chk("t1_idle", busy, 1'b0);

      // Simultaneous IF and MEM store
      if_req_valid = 1; if_req_addr = 64'h200;
      mem_req_valid = 1; mem_req_addr = 64'h100; mem_req_wen = 1; mem_req_wdata = 64'hAA; mem_req_wmask = 8'h01;
      settle();
      chk("t2_grant", {if_req_ready, mem_req_ready}, 2'b01);
      tick();
      mem_req_valid = 0; bus_req_ready = 1;
      settle();
      chk("t2_issue", {bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask},
          {1'b1, 64'h100, 1'b1, 64'hAA, 8'h01});
      tick();
      bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_data = 64'h0;
      settle();
      chk("t2_rsp", {mem_rsp_valid, if_rsp_valid}, 2'b10);
      tick();
      bus_rsp_valid = 0;
      settle();
      chk("t2_if_next", {if_req_ready, mem_req_ready}, 2'b10);
      tick();
      finish_txn();
      clear_inputs();

      // Starvation guard: MEM x4, IF, MEM x4, IF
      for (int g = 0; g < 10; g++) begin
         exp_mem = (g % 5) != 4;
         do_txn(1, 1, who);
         chk($sformatf("starve%0d", g), who, exp_mem ? 1 : 0);
      end
      clear_inputs();

      // Flush during a stalled issue
      if_req_valid = 1; if_req_addr = 64'h300;
      settle();
      chk("t4_grant", {if_req_ready, mem_req_ready}, 2'b10);
      tick();
      if_req_valid = 0;
      for (int k = 0; k < 3; k++) begin
         if_flush = (k == 0);
         settle();
         chk($sformatf("t4_hold%0d", k), {bus_req_valid, bus_req_addr}, {1'b1, 64'h300});
         tick();
      end
      if_flush = 0; bus_req_ready = 1;
      tick();
      bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_data = 64'h5555;
      settle();
      chk("t4_dropped", {if_rsp_valid, mem_rsp_valid, busy}, 3'b001);
      tick();
      bus_rsp_valid = 0; mem_req_valid = 1; mem_req_addr = 64'h500; mem_req_wen = 0;
      settle();
      chk("t4_mem_next", {if_req_ready, mem_req_ready}, 2'b01);
      tick();
      finish_txn();
      clear_inputs();

      // Timeout on a MEM load
      mem_req_valid = 1; mem_req_addr = 64'h400;
      settle();
      chk("t5_grant", mem_req_ready, 1'b1);
      tick();
      mem_req_valid = 0; bus_req_ready = 1;
      tick();
      bus_req_ready = 0; bus_rsp_data = 64'hDEAD_BEEF;
      for (int w = 1; w <= 8; w++) begin
         settle();
         if (w < 8)
            chk($sformatf("t5_wait%0d", w), {bus_timeout, mem_rsp_valid, if_rsp_valid}, 3'b000);
         else
            chk("t5_timeout", {bus_timeout, mem_rsp_valid, mem_rsp_data, if_rsp_valid}, {1'b1, 1'b1, 64'h0, 1'b0});
         tick();
      end
      bus_rsp_valid = 1;
      settle();
      chk("t5_late_rsp", {if_rsp_valid, mem_rsp_valid, bus_timeout, busy}, 4'b0000);
      tick();
      clear_inputs();

      // Reset in WAIT after the MEM streak has built up
      for (int g = 0; g < 3; g++) begin
         do_txn(1, 1, who);
         chk($sformatf("t6_streak%0d", g), who, 1);
      end
      if_req_valid = 1; mem_req_valid = 1;
      settle();
      chk("t6_grant4", {if_req_ready, mem_req_ready}, 2'b01);
      tick();
      if_req_valid = 0; mem_req_valid = 0; bus_req_ready = 1;
      tick();
      bus_req_ready = 0; if_req_valid = 1; mem_req_valid = 1; rst_n = 0;
      settle();
      chk("t6_reset_outs", outs, '0);
      tick();
      rst_n = 1; bus_rsp_valid = 1; bus_rsp_data = 64'h77;
      settle();
      chk("t6_after_reset", {if_req_ready, mem_req_ready, if_rsp_valid, mem_rsp_valid}, 4'b0100);
      tick();
      finish_txn();
      clear_inputs();

      // Randomized run against the model
      rst_n = 0;
      tick();
      rst_n = 1;
      m_act = 0; m_mem = 0; m_sent = 0; m_drop = 0; m_wen = 0;
      m_wait = 0; m_streak = 0; m_addr = '0; m_wdata = '0; m_mask = '0;
      for (int c = 0; c < 3000; c++) begin
         logic if_ok, e_if_rdy, e_mem_rdy, e_bvld, got_rsp, expired, done, e_if_rsp, e_mem_rsp;
         logic [DW-1:0] e_if_d, e_mem_d;
         if_req_valid  = ($urandom_range(0, 1) == 1);
         if_req_addr   = {$urandom, $urandom};
         if_flush      = ($urandom_range(0, 9) == 0);
         mem_req_valid = ($urandom_range(0, 1) == 1);
         mem_req_addr  = {$urandom, $urandom};
         mem_req_wen   = ($urandom_range(0, 1) == 1);
         mem_req_wdata = {$urandom, $urandom};
         mem_req_wmask = 8'($urandom);
         bus_req_ready = ($urandom_range(0, 4) < 3);
         bus_rsp_valid = ($urandom_range(0, 3) == 0);
         bus_rsp_data  = {$urandom, $urandom};
         settle();

         if_ok     = if_req_valid && !if_flush;
         e_mem_rdy = !m_act && mem_req_valid && !(if_ok && m_streak == MAXS);
         e_if_rdy  = !m_act && if_ok && !e_mem_rdy;
         e_bvld    = m_act && !m_sent;
         got_rsp   = m_act && m_sent && bus_rsp_valid;
         expired   = m_act && m_sent && !bus_rsp_valid && (m_wait + 1 == TMO);
         done      = got_rsp || expired;
         e_mem_rsp = done && m_mem;
         e_if_rsp  = done && !m_mem && !m_drop && !if_flush;
         e_mem_d   = (e_mem_rsp && got_rsp) ? bus_rsp_data : '0;
         e_if_d    = (e_if_rsp && got_rsp) ? bus_rsp_data : '0;
         chk($sformatf("rnd%0d", c),
             {if_req_ready, mem_req_ready, bus_req_valid, if_rsp_valid, if_rsp_data, mem_rsp_valid, mem_rsp_data, bus_timeout, busy},
             {e_if_rdy, e_mem_rdy, e_bvld, e_if_rsp, e_if_d, e_mem_rsp, e_mem_d, expired, m_act});
         if (e_bvld)
            chk($sformatf("rnd_bus%0d", c), {bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask},
                {m_addr, m_wen, m_wdata, m_mask});

         if (!m_act) begin
            if (e_mem_rdy || e_if_rdy) begin
               m_act = 1; m_mem = e_mem_rdy; m_sent = 0; m_wait = 0; m_drop = 0;
               m_addr  = e_mem_rdy ? mem_req_addr : if_req_addr;
               m_wen   = e_mem_rdy && mem_req_wen;
               m_wdata = e_mem_rdy ? mem_req_wdata : '0;
               m_mask  = e_mem_rdy ? mem_req_wmask : 8'h00;
               if (e_if_rdy) m_streak = 0;
               else if (if_ok) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
               else m_streak = 0;
            end
         end else begin
            if (if_flush && !m_mem) m_drop = 1;
            if (!m_sent) begin
               if (bus_req_ready) m_sent = 1;
            end else if (done) begin
               m_act = 0;
            end else begin
               m_wait++;
            end
         end
         tick();
      end
      clear_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- At most one transaction is outstanding at any time.
- MEM has priority, with a starvation guard for IF.
- Supports IF flush on redirect, where the IF response is dropped, and a response timeout.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
MAX_MEM_STREAK, 4, consecutive MEM grants allowed while IF waits before IF is forced through
TIMEOUT, 255, WAIT cycles before an aborted transaction is reported

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle
if_req_addr  in  ADDR_W  fetch address
if_flush  in  1  pipeline redirect; cancel or drop the IF transaction
if_rsp_valid  out  1  fetch data valid (1-cycle pulse)
if_rsp_data  out  DATA_W  fetch data
mem_req_valid  in  1  load/store request
mem_req_ready  out  1  load/store request accepted this cycle
mem_req_addr  in  ADDR_W  load/store address
mem_req_wen  in  1  1 = store
mem_req_wdata  in  DATA_W  store data
mem_req_wmask  in  8  store byte mask
mem_rsp_valid  out  1  load data / store acknowledge (pulse)
mem_rsp_data  out  DATA_W  load data
bus_req_valid  out  1  downstream request
bus_req_ready  in  1  downstream accepts request
bus_req_addr  out  ADDR_W  latched address
bus_req_wen  out  1  latched write enable (0 for IF)
bus_req_wdata  out  DATA_W  latched store data
bus_req_wmask  out  8  latched mask (0 for IF)
bus_rsp_valid  in  1  downstream response
bus_rsp_data  in  DATA_W  downstream read data
bus_timeout  out  1  pulse when a transaction is aborted by timeout
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- Reset (async, rst_n=0):
  - State IDLE; owner, drop flag, streak counter and timeout counter all cleared.
  - All outputs 0; latched bus fields 0.
  - Reset mid-transaction abandons it; a bus response arriving after reset is ignored.
- IDLE arbitration (combinational ready, same cycle):
  - IF is eligible when if_req_valid=1 and if_flush=0.
  - MEM eligible only → grant MEM.
  - IF eligible only → grant IF.
  - Both eligible → grant MEM, unless streak == MAX_MEM_STREAK, in which case grant IF.
  - On grant: pulse the winner's req_ready; latch addr/wen/wdata/wmask (IF: wen=0, wmask=0, wdata=0); record owner; go to ISSUE.
- Streak counter:
  - MEM grant while IF eligible → +1, saturating at MAX_MEM_STREAK.
  - MEM grant while IF not eligible → 0.
  - Any IF grant → 0.
- ISSUE:
  - bus_req_valid=1 with the latched fields, held stable until bus_req_ready=1, then go to WAIT.
  - No cancellation of an issued request.
- WAIT:
  - Timeout counter increments each cycle.
  - On bus_rsp_valid: pulse the owner's rsp_valid in the same cycle; rsp_data = bus_rsp_data (combinational pass-through, else 0). Go to IDLE.
  - A new grant is possible the next cycle.
- Minimum latency: accept at T, ISSUE at T+1 (with ready), response at T+2 earliest; back-to-back accept at T+3.
- Flush:
  - if_flush=1 while owner=IF in ISSUE or WAIT sets the drop flag.
  - The transaction still completes on the bus; if_rsp_valid is suppressed for it. The drop flag clears on return to IDLE.
  - if_flush in the same cycle as the response also suppresses the response.
  - if_flush has no effect when owner=MEM.
- Timeout:
  - When the counter reaches TIMEOUT in WAIT without a response: pulse bus_timeout, pulse the owner's rsp_valid with data 0 (still suppressed if dropped), go to IDLE.
  - bus_rsp_valid seen in IDLE or ISSUE is ignored.
- Only one of if_rsp_valid / mem_rsp_valid is ever high; never both req_ready signals in one cycle.

Test Plan:
- Single IF read: if_req_valid, addr 0x80000000; bus_req_ready=1 immediately; rsp 2 cycles later with data 0x1234 → if_req_ready at T, bus_req_valid at T+1 with addr 0x80000000 / wen 0, if_rsp_valid at T+2 with 0x1234, busy low at T+3.
- Simultaneous requests: IF and MEM store (addr 0x100, wdata 0xAA, wmask 0x01) both valid → MEM granted first with bus_req_wen=1 / wmask 0x01; IF granted on the next IDLE.
- Starvation: IF held valid while MEM requests continuously, MAX_MEM_STREAK=4 → grant order MEM×4, IF, MEM×4, IF.
- Flush: IF granted; bus_req_ready delayed 3 cycles; if_flush pulsed in ISSUE → bus transaction completes, if_rsp_valid stays 0, next MEM request is granted normally.
- Timeout: TIMEOUT=8; MEM load issued, no bus_rsp_valid → bus_timeout and mem_rsp_valid pulse with data 0 in the 8th WAIT cycle; a late bus_rsp_valid in IDLE produces no output.
- Reset in WAIT: rst_n low for 1 cycle mid-transaction → all outputs 0 immediately, state IDLE, streak counter 0; the next request is granted normally.
